// File: rtl/cpu_hazard_pkg.sv
// Shared types for the pipeline hazard controller and the forwarding datapath.
package cpu_hazard_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned LU_CNT_W   = 2;

   // Forwarding mux select, also decoded by forwarding_unit.
   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_EX   = 2'b01,
      FWD_MA   = 2'b10,
      FWD_WB   = 2'b11
   } fwd_sel_t;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      LU_STALL = 2'b01,
      DIV_BUSY = 2'b10
   } hz_state_t;

   // Pipeline-register and PC control bundle.
   typedef struct packed {
      logic stall_pc;
      logic stall_if_id;
      logic hold_id_ex;
      logic bubble_id_ex;
      logic bubble_ex_ma;
      logic flush_if_id;
      logic div_busy;
   } hz_ctrl_t;

   // True when a written destination supplies the given source operand.
   function automatic logic dest_hits(input logic [REG_ADDR_W-1:0] src,
                                      input logic [REG_ADDR_W-1:0] rd,
                                      input logic                  we);
      return we && (rd == src);
   endfunction

endpackage

// File: rtl/hazard_control_unit_forward_select.sv
// Per-source producer priority comparator: picks the youngest in-flight writer
// of one ID-stage source and flags when that writer is a load.
module forward_select
   import cpu_hazard_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] src_addr_i,
   input  logic                  src_used_i,
   input  logic [REG_ADDR_W-1:0] rd_ex_i,
   input  logic [REG_ADDR_W-1:0] rd_ma_i,
   input  logic [REG_ADDR_W-1:0] rd_wb_i,
   input  logic                  we_ex_i,
   input  logic                  we_ma_i,
   input  logic                  we_wb_i,
   input  logic                  mem_read_ex_i,
   input  logic                  mem_read_ma_i,
   output fwd_sel_t              fwd_sel_o,
   output logic                  lu_ex_o,
   output logic                  lu_ma_o
);

   logic src_live;

   assign src_live = src_used_i && (src_addr_i != '0);

   // EX is the youngest producer, so it wins over MA, which wins over WB.
   always_comb begin
      fwd_sel_o = FWD_NONE;
      lu_ex_o   = 1'b0;
      lu_ma_o   = 1'b0;
      if (src_live) begin
         if (dest_hits(src_addr_i, rd_ex_i, we_ex_i)) begin
            fwd_sel_o = FWD_EX;
            lu_ex_o   = mem_read_ex_i;
         end else if (dest_hits(src_addr_i, rd_ma_i, we_ma_i)) begin
            fwd_sel_o = FWD_MA;
            lu_ma_o   = mem_read_ma_i;
         end else if (dest_hits(src_addr_i, rd_wb_i, we_wb_i)) begin
            fwd_sel_o = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage core: forwarding selects, load-use stalls,
// divide stalls and taken-branch flushes.
// Define HAZARD_DIV_STALL_EN to build the multi-cycle divider stall path.
module hazard_control_unit
   import cpu_hazard_pkg::*;
#(
   parameter int unsigned DIV_LATENCY = 32
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] rs1_addr_id,
   input  logic [REG_ADDR_W-1:0] rs2_addr_id,
   input  logic                  rs1_used_id,
   input  logic                  rs2_used_id,
   input  logic [REG_ADDR_W-1:0] rd_ex,
   input  logic [REG_ADDR_W-1:0] rd_ma,
   input  logic [REG_ADDR_W-1:0] rd_wb,
   input  logic                  reg_write_enable_ex,
   input  logic                  reg_write_enable_ma,
   input  logic                  reg_write_enable_wb,
   input  logic                  mem_read_ex,
   input  logic                  mem_read_ma,
   input  logic                  div_id,
   input  logic                  branch_taken_ex,
   output logic [1:0]            forward_rs1,
   output logic [1:0]            forward_rs2,
   output logic                  stall_pc,
   output logic                  stall_if_id,
   output logic                  hold_id_ex,
   output logic                  bubble_id_ex,
   output logic                  bubble_ex_ma,
   output logic                  flush_if_id,
   output logic                  div_busy
);

`ifdef HAZARD_DIV_STALL_EN
   localparam int unsigned CNT_W = $clog2(DIV_LATENCY) + 1;
   localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LATENCY - 2);
`else
   localparam int unsigned CNT_W = LU_CNT_W;
   localparam logic [CNT_W-1:0] DIV_CNT_INIT = '0;
`endif

   hz_state_t        state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   hz_ctrl_t         ctrl;

   fwd_sel_t fwd_rs1, fwd_rs2;
   logic     rs1_lu_ex, rs1_lu_ma, rs2_lu_ex, rs2_lu_ma;
   logic     lu_hit_ex, lu_hit, div_start;

   forward_select u_fwd_rs1 (
      .src_addr_i    (rs1_addr_id),
      .src_used_i    (rs1_used_id),
      .rd_ex_i       (rd_ex),
      .rd_ma_i       (rd_ma),
      .rd_wb_i       (rd_wb),
      .we_ex_i       (reg_write_enable_ex),
      .we_ma_i       (reg_write_enable_ma),
      .we_wb_i       (reg_write_enable_wb),
      .mem_read_ex_i (mem_read_ex),
      .mem_read_ma_i (mem_read_ma),
      .fwd_sel_o     (fwd_rs1),
      .lu_ex_o       (rs1_lu_ex),
      .lu_ma_o       (rs1_lu_ma)
   );

   forward_select u_fwd_rs2 (
      .src_addr_i    (rs2_addr_id),
      .src_used_i    (rs2_used_id),
      .rd_ex_i       (rd_ex),
      .rd_ma_i       (rd_ma),
      .rd_wb_i       (rd_wb),
      .we_ex_i       (reg_write_enable_ex),
      .we_ma_i       (reg_write_enable_ma),
      .we_wb_i       (reg_write_enable_wb),
      .mem_read_ex_i (mem_read_ex),
      .mem_read_ma_i (mem_read_ma),
      .fwd_sel_o     (fwd_rs2),
      .lu_ex_o       (rs2_lu_ex),
      .lu_ma_o       (rs2_lu_ma)
   );

   // A load in EX forces the longer wait even when the other source hits MA.
   assign lu_hit_ex = rs1_lu_ex | rs2_lu_ex;
   assign lu_hit    = lu_hit_ex | rs1_lu_ma | rs2_lu_ma;

`ifdef HAZARD_DIV_STALL_EN
   assign div_start = div_id;
`else
   logic unused_div_cfg;
   assign div_start      = 1'b0;
   assign unused_div_cfg = ^{div_id, 32'(DIV_LATENCY)};
`endif

   // State and stall counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Next-state and control decode; reset masks every control output at once.
   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      ctrl        = '0;
      case (state_q)
         IDLE: begin
            if (branch_taken_ex) begin
               ctrl.flush_if_id  = 1'b1;
               ctrl.bubble_id_ex = 1'b1;
               stall_cnt_d       = '0;
            end else if (lu_hit) begin
               ctrl.stall_pc     = 1'b1;
               ctrl.stall_if_id  = 1'b1;
               ctrl.bubble_id_ex = 1'b1;
               state_d           = LU_STALL;
               stall_cnt_d       = lu_hit_ex ? CNT_W'(1) : '0;
            end else if (div_start) begin
               state_d     = DIV_BUSY;
               stall_cnt_d = DIV_CNT_INIT;
            end
         end
         LU_STALL: begin
            if (branch_taken_ex) begin
               ctrl.flush_if_id  = 1'b1;
               ctrl.bubble_id_ex = 1'b1;
               state_d           = IDLE;
               stall_cnt_d       = '0;
            end else if (stall_cnt_q != '0) begin
               ctrl.stall_pc     = 1'b1;
               ctrl.stall_if_id  = 1'b1;
               ctrl.bubble_id_ex = 1'b1;
               stall_cnt_d       = stall_cnt_q - CNT_W'(1);
            end else begin
               // The consumer issues now; if it is a divide it enters EX here.
               state_d     = div_start ? DIV_BUSY : IDLE;
               stall_cnt_d = div_start ? DIV_CNT_INIT : '0;
            end
         end
`ifdef HAZARD_DIV_STALL_EN
         DIV_BUSY: begin
            ctrl.stall_pc     = 1'b1;
            ctrl.stall_if_id  = 1'b1;
            ctrl.hold_id_ex   = 1'b1;
            ctrl.bubble_ex_ma = 1'b1;
            ctrl.div_busy     = 1'b1;
            if (stall_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               stall_cnt_d = stall_cnt_q - CNT_W'(1);
            end
         end
`endif
         default: begin
            state_d     = IDLE;
            stall_cnt_d = '0;
         end
      endcase
      if (reset) begin
         ctrl = '0;
      end
   end

   assign forward_rs1  = fwd_rs1;
   assign forward_rs2  = fwd_rs2;
   assign stall_pc     = ctrl.stall_pc;
   assign stall_if_id  = ctrl.stall_if_id;
   assign hold_id_ex   = ctrl.hold_id_ex;
   assign bubble_id_ex = ctrl.bubble_id_ex;
   assign bubble_ex_ma = ctrl.bubble_ex_ma;
   assign flush_if_id  = ctrl.flush_if_id;
   assign div_busy     = ctrl.div_busy;

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the RV32IM 5-stage core. Compares ID-stage source registers against EX/MA/WB destinations and drives the 2-bit forwarding selects consumed by `forwarding_unit`. Also sequences load-use stalls, multi-cycle divide stalls and taken-branch flushes through a small state machine. Sits beside the ID stage; all outputs go to pipeline registers and the PC.

## Interface
- `DIV_LATENCY`, 32: EX-stage cycles a DIV/DIVU/REM/REMU occupies (≥2).
- `clk` in 1: core clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `rs1_addr_id`, `rs2_addr_id` in 5: ID-stage source registers.
- `rs1_used_id`, `rs2_used_id` in 1: the instruction reads that source.
- `rd_ex`, `rd_ma`, `rd_wb` in 5: destination registers.
- `reg_write_enable_ex`, `reg_write_enable_ma`, `reg_write_enable_wb` in 1: the destination is written.
- `mem_read_ex`, `mem_read_ma` in 1: a load occupies that stage.
- `div_id` in 1: the ID instruction is a divide/remainder.
- `branch_taken_ex` in 1: redirect resolved in EX.
- `forward_rs1`, `forward_rs2` out 2: 00 none, 01 EX, 10 MA, 11 WB.
- `stall_pc`, `stall_if_id` out 1: hold the PC and the IF/ID register.
- `hold_id_ex` out 1: hold the ID/EX register (divide in flight).
- `bubble_id_ex` out 1: load a NOP into ID/EX.
- `bubble_ex_ma` out 1: load a NOP into EX/MA.
- `flush_if_id` out 1: squash IF/ID.
- `div_busy` out 1: divider occupied.

## Operation
- Forward select per source. If used==0 or addr==x0 → 00. Otherwise the first matching stage with write-enable set wins, in priority EX(01) > MA(10) > WB(11). With no match → 00.
- Load-use: a load in EX (MA) whose rd matches a used source needs a 2-cycle (1-cycle) stall. Load data is forwarded only from WB.
- FSM states: IDLE, LU_STALL, DIV_BUSY. `stall_cnt` is $clog2(DIV_LATENCY)+1 bits.
- IDLE → LU_STALL on a load-use hit, with `stall_cnt` = 1 (load in EX) or 0 (load in MA).
  - In the hit cycle and each LU_STALL cycle: `stall_pc`=`stall_if_id`=`bubble_id_ex`=1.
  - LU_STALL decrements to 0 and then returns to IDLE. The consumer issues in that cycle with select 11.
- IDLE → DIV_BUSY in the cycle after the divide moves ID→EX, with `stall_cnt`=DIV_LATENCY-2.
  - In DIV_BUSY: `stall_pc`=`stall_if_id`=`hold_id_ex`=`bubble_ex_ma`=`div_busy`=1.
  - The state exits to IDLE when the count reaches 0. The divide advances to MA in the following cycle.
- A load-use hit detected while in DIV_BUSY is deferred until IDLE.
- `branch_taken_ex` has top priority in IDLE and LU_STALL. It asserts `flush_if_id`=`bubble_id_ex`=1, clears all stalls that cycle and forces the FSM to IDLE.
- `branch_taken_ex` in DIV_BUSY is impossible because the divider holds EX. It is ignored.

## Timing
- Forward selects, load-use detection and flush are combinational from the current-cycle inputs. The state and counter update on the rising `clk` edge.
- Divide stall: exactly DIV_LATENCY-1 stall cycles.
- Load-use stall: 2 cycles for a load in EX, 1 cycle for a load in MA.
- `reset` asserted, at any time including mid-stall: state=IDLE, `stall_cnt`=0.
  - All stall, hold, bubble, flush and busy outputs are 0.
  - `forward_rs1`/`forward_rs2` stay combinational; they read 00 whenever the inputs are all 0.
- First edge after reset deassertion: normal IDLE evaluation.

## Configuration
- `HAZARD_DIV_STALL_EN` defined: DIV_BUSY state, counter path and `div_busy` present as above.
- Undefined (single-cycle/absent divider):
  - DIV_BUSY is not built and `div_id` is ignored.
  - `hold_id_ex`, `bubble_ex_ma` and `div_busy` are tied to 0.
  - The counter is sized for load-use only (2 bits).

## Structure
- Package `cpu_hazard_pkg` holds:
  - `fwd_sel_t` encodings FWD_NONE/FWD_EX/FWD_MA/FWD_WB (00/01/10/11), shared with `forwarding_unit`.
  - `hz_state_t` {IDLE, LU_STALL, DIV_BUSY}.
- Sub-module `forward_select` holds the per-source priority comparator. It is instantiated twice (rs1, rs2) and also yields the per-source load-use hit bit.

## Test plan
- rs1=5 used; rd_ex=5 and rd_ma=5, both writing, no loads → `forward_rs1`=01. Repeat with rs1=0 → 00.
- Load to x7 in EX, ID reads x7 via rs2 → 2 stall cycles with `bubble_id_ex`=1, then `forward_rs2`=11 and `stall_pc`=0.
- Load to x7 in MA, ID reads x7 → exactly 1 stall cycle, then select 11.
- `HAZARD_DIV_STALL_EN`, DIV_LATENCY=4: divide issues → `div_busy`=1 for 3 cycles, `hold_id_ex`=1; the instruction behind it issues on cycle 5.
- Load-use stall in progress, then `branch_taken_ex`=1 → `flush_if_id`=1 and `stall_pc`=0 that cycle; FSM=IDLE the next cycle.
- `reset` pulsed during DIV_BUSY with 10 cycles remaining → all control outputs 0 immediately; the next instruction issues without stall.
